tlb_refill_walker: RTL and testbench



---
 rtl/tlb_refill_walker.sv | 163 ++++++++++++++++
 tb/tb_tlb_refill_walker.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_refill_walker.sv
// TLB refill walker: on a miss, reads one PTE from a flat word-indexed page table
// and either installs the translation through the TLB write port or reports a fault.
module tlb_refill_walker #(
    parameter logic [31:0] PT_BASE        = 32'h0001_0000,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter int          CORE_ID        = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        miss_valid,
    input  logic [31:0] miss_vaddr,
    output logic        miss_ready,
    input  logic        abort,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data_in,
    output logic        tlb_we,
    output logic        tlb_priv,
    output logic [31:0] tlb_vaddr_out,
    output logic [19:0] tlb_paddr_out,
    output logic        walk_done,
    output logic        page_fault,
    output logic [31:0] fault_vaddr
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, RESP} state_t;

    state_t             state_q, state_d;
    logic [31:0]        vaddr_q, vaddr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               miss_ready_q, miss_ready_d;
    logic               mem_req_q, mem_req_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic               tlb_we_q, tlb_we_d;
    logic               tlb_priv_q, tlb_priv_d;
    logic [31:0]        tlb_vaddr_q, tlb_vaddr_d;
    logic [19:0]        tlb_paddr_q, tlb_paddr_d;
    logic               walk_done_q, walk_done_d;
    logic               page_fault_q, page_fault_d;
    logic [31:0]        fault_vaddr_q, fault_vaddr_d;

    // PTE bits [30:20] are reserved; CORE_ID only tags traffic at the arbiter.
    logic unused_s;
    assign unused_s = ^{mem_data_in[30:20], 1'(CORE_ID)};

    // Next-state and registered-output computation.
    always_comb begin
        state_d       = state_q;
        vaddr_d       = vaddr_q;
        cnt_d         = '0;
        miss_ready_d  = 1'b0;
        mem_req_d     = 1'b0;
        mem_addr_d    = 32'h0000_0000;
        tlb_we_d      = 1'b0;
        tlb_priv_d    = 1'b0;
        tlb_vaddr_d   = 32'h0000_0000;
        tlb_paddr_d   = 20'h0_0000;
        walk_done_d   = 1'b0;
        page_fault_d  = 1'b0;
        fault_vaddr_d = fault_vaddr_q;

        case (state_q)
            IDLE: begin
                if (miss_valid && !abort) begin
                    state_d    = REQ;
                    vaddr_d    = miss_vaddr;
                    mem_req_d  = 1'b1;
                    mem_addr_d = PT_BASE + {10'b00_0000_0000, miss_vaddr[31:12], 2'b00};
                end else begin
                    miss_ready_d = 1'b1;
                end
            end
            REQ: begin
                if (abort) begin
                    state_d      = IDLE;
                    miss_ready_d = 1'b1;
                end else if (mem_ready) begin
                    if (mem_data_in[31]) begin
                        state_d     = WRITE;
                        tlb_we_d    = 1'b1;
                        tlb_priv_d  = 1'b1;
                        tlb_vaddr_d = vaddr_q;
                        tlb_paddr_d = mem_data_in[19:0];
                    end else begin
                        state_d       = RESP;
                        page_fault_d  = 1'b1;
                        fault_vaddr_d = vaddr_q;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // A response in the final cycle is taken above, so it wins over the timeout.
                    state_d       = RESP;
                    page_fault_d  = 1'b1;
                    fault_vaddr_d = vaddr_q;
                end else begin
                    cnt_d      = cnt_q + CNT_W'(1);
                    mem_req_d  = 1'b1;
                    mem_addr_d = mem_addr_q;
                end
            end
            WRITE: begin
                // The install is atomic: abort is not consulted here.
                state_d     = RESP;
                walk_done_d = 1'b1;
            end
            RESP: begin
                state_d      = IDLE;
                miss_ready_d = 1'b1;
            end
            default: begin
                state_d      = IDLE;
                miss_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            vaddr_q       <= 32'h0000_0000;
            cnt_q         <= '0;
            miss_ready_q  <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0000_0000;
            tlb_we_q      <= 1'b0;
            tlb_priv_q    <= 1'b0;
            tlb_vaddr_q   <= 32'h0000_0000;
            tlb_paddr_q   <= 20'h0_0000;
            walk_done_q   <= 1'b0;
            page_fault_q  <= 1'b0;
            fault_vaddr_q <= 32'h0000_0000;
        end else begin
            state_q       <= state_d;
            vaddr_q       <= vaddr_d;
            cnt_q         <= cnt_d;
            miss_ready_q  <= miss_ready_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            tlb_we_q      <= tlb_we_d;
            tlb_priv_q    <= tlb_priv_d;
            tlb_vaddr_q   <= tlb_vaddr_d;
            tlb_paddr_q   <= tlb_paddr_d;
            walk_done_q   <= walk_done_d;
            page_fault_q  <= page_fault_d;
            fault_vaddr_q <= fault_vaddr_d;
        end
    end

    assign miss_ready    = miss_ready_q;
    assign mem_req       = mem_req_q;
    assign mem_addr      = mem_addr_q;
    assign tlb_we        = tlb_we_q;
    assign tlb_priv      = tlb_priv_q;
    assign tlb_vaddr_out = tlb_vaddr_q;
    assign tlb_paddr_out = tlb_paddr_q;
    assign walk_done     = walk_done_q;
    assign page_fault    = page_fault_q;
    assign fault_vaddr   = fault_vaddr_q;

endmodule

// File: tb/tb_tlb_refill_walker.sv
// Directed bench for tlb_refill_walker: refill, invalid PTE, timeout, abort,
// address wrap, reset mid-walk and back-to-back misses.
module tb_tlb_refill_walker;

    logic        clk;
    logic        reset;
    logic        miss_valid;
    logic [31:0] miss_vaddr;
    logic        abort;
    logic        mem_ready;
    logic [31:0] mem_data_in;

    logic        miss_ready, mem_req, tlb_we, tlb_priv, walk_done, page_fault;
    logic [31:0] mem_addr, tlb_vaddr_out, fault_vaddr;
    logic [19:0] tlb_paddr_out;

    logic        w_miss_ready, w_mem_req, w_tlb_we, w_tlb_priv, w_walk_done, w_page_fault;
    logic [31:0] w_mem_addr, w_tlb_vaddr_out, w_fault_vaddr;
    logic [19:0] w_tlb_paddr_out;

    int vectors = 0;
    int errs    = 0;

    tlb_refill_walker dut (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_vaddr(miss_vaddr),
        .miss_ready(miss_ready), .abort(abort), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_data_in(mem_data_in), .tlb_we(tlb_we),
        .tlb_priv(tlb_priv), .tlb_vaddr_out(tlb_vaddr_out), .tlb_paddr_out(tlb_paddr_out),
        .walk_done(walk_done), .page_fault(page_fault), .fault_vaddr(fault_vaddr)
    );

    // Second instance with a base near the top of the address space, sharing all inputs.
    tlb_refill_walker #(.PT_BASE(32'hFFFF_FFF0)) u_wrap (
        .clk(clk), .reset(reset), .miss_valid(miss_valid), .miss_vaddr(miss_vaddr),
        .miss_ready(w_miss_ready), .abort(abort), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
        .mem_ready(mem_ready), .mem_data_in(mem_data_in), .tlb_we(w_tlb_we),
        .tlb_priv(w_tlb_priv), .tlb_vaddr_out(w_tlb_vaddr_out), .tlb_paddr_out(w_tlb_paddr_out),
        .walk_done(w_walk_done), .page_fault(w_page_fault), .fault_vaddr(w_fault_vaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int  n;
        bit  seen;

        reset       = 1'b1;
        miss_valid  = 1'b0;
        miss_vaddr  = 32'h0;
        abort       = 1'b0;
        mem_ready   = 1'b0;
        mem_data_in = 32'h0;
        step();
        step();
        chk("rst_miss_ready", 32'(miss_ready), 32'h1);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_tlb_we", 32'(tlb_we), 32'h0);
        chk("rst_pulses", 32'({walk_done, page_fault}), 32'h0);
        chk("rst_fault_vaddr", fault_vaddr, 32'h0);
        reset = 1'b0;
        step();

        // Basic refill: accept at edge 0, WRITE in cycle 2, walk_done in cycle 3.
        miss_valid = 1'b1;
        miss_vaddr = 32'h0000_3ABC;
        step();
        miss_valid = 1'b0;
        chk("basic_mem_req", 32'(mem_req), 32'h1);
        chk("basic_mem_addr", mem_addr, 32'h0001_000C);
        chk("basic_miss_ready_busy", 32'(miss_ready), 32'h0);
        mem_ready   = 1'b1;
        mem_data_in = 32'h8000_5000;
        step();
        mem_ready = 1'b0;
        chk("basic_tlb_we", 32'(tlb_we), 32'h1);
        chk("basic_tlb_priv", 32'(tlb_priv), 32'h1);
        chk("basic_tlb_vaddr", tlb_vaddr_out, 32'h0000_3ABC);
        chk("basic_tlb_paddr", 32'(tlb_paddr_out), 32'h0000_5000);
        chk("basic_mem_req_drop", 32'(mem_req), 32'h0);
        chk("basic_done_early", 32'(walk_done), 32'h0);
        step();
        chk("basic_walk_done", 32'(walk_done), 32'h1);
        chk("basic_tlb_we_off", 32'(tlb_we), 32'h0);
        chk("basic_tlb_vaddr_off", tlb_vaddr_out, 32'h0);
        chk("basic_resp_not_ready", 32'(miss_ready), 32'h0);
        step();
        chk("basic_done_pulse", 32'(walk_done), 32'h0);
        chk("basic_idle_ready", 32'(miss_ready), 32'h1);

        // Invalid PTE.
        miss_valid = 1'b1;
        miss_vaddr = 32'h0004_2000;
        step();
        miss_valid = 1'b0;
        chk("inv_mem_addr", mem_addr, 32'h0001_0108);
        mem_ready   = 1'b1;
        mem_data_in = 32'h0000_7000;
        step();
        mem_ready = 1'b0;
        chk("inv_page_fault", 32'(page_fault), 32'h1);
        chk("inv_fault_vaddr", fault_vaddr, 32'h0004_2000);
        chk("inv_no_tlb_we", 32'(tlb_we), 32'h0);
        step();
        chk("inv_fault_pulse", 32'(page_fault), 32'h0);
        chk("inv_no_walk_done", 32'(walk_done), 32'h0);
        chk("inv_fault_hold", fault_vaddr, 32'h0004_2000);

        // Timeout: mem_req must stay high for exactly 64 cycles.
        miss_valid = 1'b1;
        miss_vaddr = 32'h0000_5000;
        step();
        miss_valid = 1'b0;
        chk("to_mem_addr", mem_addr, 32'h0001_0014);
        n    = mem_req ? 1 : 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step();
            if (mem_req) n++;
            if (page_fault) seen = 1'b1;
        end
        chk("to_fault_seen", 32'(seen), 32'h1);
        chk("to_req_cycles", 32'(n), 32'd64);
        chk("to_fault_vaddr", fault_vaddr, 32'h0000_5000);
        step();

        // mem_ready in the 64th REQ cycle beats the timeout.
        miss_valid = 1'b1;
        miss_vaddr = 32'h0000_6000;
        step();
        miss_valid = 1'b0;
        for (int i = 0; i < 63; i++) step();
        chk("edge_req_64th", 32'(mem_req), 32'h1);
        mem_ready   = 1'b1;
        mem_data_in = 32'h800A_BCDE;
        step();
        mem_ready = 1'b0;
        chk("edge_tlb_we", 32'(tlb_we), 32'h1);
        chk("edge_tlb_paddr", 32'(tlb_paddr_out), 32'h000A_BCDE);
        chk("edge_no_fault", 32'(page_fault), 32'h0);
        step();
        chk("edge_walk_done", 32'(walk_done), 32'h1);
        chk("edge_fault_vaddr_hold", fault_vaddr, 32'h0000_5000);
        step();

        // Abort in the second REQ cycle, late valid response ignored.
        miss_valid = 1'b1;
        miss_vaddr = 32'h0000_7000;
        step();
        miss_valid = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort       = 1'b0;
        mem_ready   = 1'b1;
        mem_data_in = 32'h8000_1000;
        chk("abort_req_drop", 32'(mem_req), 32'h0);
        step();
        mem_ready = 1'b0;
        chk("abort_no_tlb_we", 32'(tlb_we), 32'h0);
        chk("abort_ready", 32'(miss_ready), 32'h1);
        step();
        chk("abort_no_pulses", 32'({walk_done, page_fault}), 32'h0);

        // Abort in IDLE blocks acceptance; then address wrap on the second instance.
        miss_valid = 1'b1;
        miss_vaddr = 32'h0000_8000;
        abort      = 1'b1;
        step();
        chk("idle_abort_blocks", 32'(mem_req), 32'h0);
        abort = 1'b0;
        step();
        miss_valid = 1'b0;
        chk("wrap_req", 32'(w_mem_req), 32'h1);
        chk("wrap_mem_addr", w_mem_addr, 32'h0000_0010);
        chk("wrap_main_addr", mem_addr, 32'h0001_0020);
        mem_ready   = 1'b1;
        mem_data_in = 32'h8000_0777;
        step();
        mem_ready = 1'b0;

        // Abort during WRITE does not cancel the install.
        abort = 1'b1;
        chk("wabort_tlb_we", 32'(tlb_we), 32'h1);
        step();
        abort = 1'b0;
        chk("wabort_walk_done", 32'(walk_done), 32'h1);
        step();

        // Reset in the middle of a walk.
        miss_valid = 1'b1;
        miss_vaddr = 32'h0000_9000;
        step();
        miss_valid = 1'b0;
        step();
        reset       = 1'b1;
        mem_ready   = 1'b1;
        mem_data_in = 32'h8000_0999;
        step();
        reset     = 1'b0;
        mem_ready = 1'b0;
        chk("mrst_cleared", 32'({mem_req, tlb_we, tlb_priv, walk_done, page_fault}), 32'h0);
        chk("mrst_ready", 32'(miss_ready), 32'h1);
        chk("mrst_fault_vaddr", fault_vaddr, 32'h0);
        step();
        chk("mrst_no_write", 32'({tlb_we, walk_done}), 32'h0);

        // Back-to-back misses: second held request waits for the walk to finish.
        miss_valid = 1'b1;
        miss_vaddr = 32'h0000_A000;
        step();
        miss_vaddr  = 32'h0000_B123;
        mem_ready   = 1'b1;
        mem_data_in = 32'h8000_0111;
        step();
        mem_ready = 1'b0;
        chk("b2b_first_vaddr", tlb_vaddr_out, 32'h0000_A000);
        step();
        chk("b2b_resp_busy", 32'(miss_ready), 32'h0);
        step();
        chk("b2b_idle_ready", 32'(miss_ready), 32'h1);
        chk("b2b_not_yet", 32'(mem_req), 32'h0);
        step();
        miss_valid = 1'b0;
        chk("b2b_second_addr", mem_addr, 32'h0001_002C);
        mem_ready   = 1'b1;
        mem_data_in = 32'h8000_0222;
        step();
        mem_ready = 1'b0;
        chk("b2b_second_vaddr", tlb_vaddr_out, 32'h0000_B123);
        chk("b2b_second_paddr", 32'(tlb_paddr_out), 32'h0000_0222);
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
